// File: rtl/mem_access_pkg.sv
// Shared types for the memory access controller: FSM states, RAM op codes, requester IDs.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic [1:0] RW_FETCH = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_access_arb.sv
// Two-input fetch/load-store arbiter, combinational one-hot grant while en is high; no backpressure.
// MEM_ACCESS_RR_EN: round-robin on ties (first tie to ls); otherwise ls has fixed priority.
module mem_access_arb
  import mem_access_pkg::*;
(
`ifdef MEM_ACCESS_RR_EN
  input  logic clk,
  input  logic reset_n,
`endif
  input  logic en,
  input  logic if_req,
  input  logic ls_req,
  output logic gnt_if,
  output logic gnt_ls
);

`ifdef MEM_ACCESS_RR_EN
  req_id_t last_q;
  logic    ls_wins;

  // On a tie the port that was not granted last wins.
  assign ls_wins = ls_req & (~if_req | (last_q == REQ_IF));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= REQ_IF;
    end else if (en && (if_req || ls_req)) begin
      last_q <= ls_wins ? REQ_LS : REQ_IF;
    end
  end

  assign gnt_ls = en & ls_wins;
  assign gnt_if = en & if_req & ~ls_wins;
`else
  assign gnt_ls = en & ls_req;
  assign gnt_if = en & if_req & ~ls_req;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// RAM initiator for fetch + load/store, one transaction in flight: store done at grant+2, reads valid at grant+3.
// Requests are level and held until gnt; MEM_ACCESS_RR_EN selects round-robin arbitration.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic        ls_wdone,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_rw,
  output logic [31:0] mem_din,
  output logic        mem_enable,
  input  logic [31:0] mem_dout,
  input  logic [31:0] mem_fetch
);

  state_t      state_q, state_d;
  logic        arb_en, gnt_if, gnt_ls, any_gnt;
  logic [1:0]  rw_q;
  logic [31:0] addr_q, wdata_q;
  logic        oor_q;
  logic [31:0] sel_addr;
  logic        sel_oor;
  logic        wr_done, rd_done, fe_done;

  mem_access_arb u_arb (
`ifdef MEM_ACCESS_RR_EN
    .clk     (clk),
    .reset_n (reset_n),
`endif
    .en      (arb_en),
    .if_req  (if_req),
    .ls_req  (ls_req),
    .gnt_if  (gnt_if),
    .gnt_ls  (gnt_ls)
  );

  assign any_gnt  = gnt_if | gnt_ls;
  assign if_gnt   = gnt_if;
  assign ls_gnt   = gnt_ls;
  assign sel_addr = gnt_ls ? ls_addr : if_addr;
  assign sel_oor  = |(sel_addr >> ADDR_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_gnt) state_d = ISSUE;
      ISSUE:   state_d = (rw_q == RW_WRITE) ? IDLE : CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant is gated by reset so every output is low while reset_n is asserted.
  always_comb begin
    arb_en     = 1'b0;
    mem_enable = 1'b0;
    case (state_q)
      IDLE:    arb_en     = reset_n;
      ISSUE:   mem_enable = ~oor_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rw_q    <= RW_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
    end else if (state_q == IDLE && any_gnt) begin
      rw_q   <= gnt_ls ? (ls_we ? RW_WRITE : RW_READ) : RW_FETCH;
      addr_q <= sel_addr;
      oor_q  <= sel_oor;
      if (gnt_ls && ls_we) wdata_q <= ls_wdata;
    end
  end

  assign mem_addr = addr_q;
  assign mem_rw   = rw_q;
  assign mem_din  = wdata_q;

  assign wr_done = (state_q == ISSUE)   && (rw_q == RW_WRITE);
  assign rd_done = (state_q == CAPTURE) && (rw_q == RW_READ);
  assign fe_done = (state_q == CAPTURE) && (rw_q == RW_FETCH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ls_wdone  <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_err    <= 1'b0;
      ls_rdata  <= '0;
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
    end else begin
      ls_wdone  <= wr_done;
      ls_rvalid <= rd_done;
      ls_err    <= oor_q & (wr_done | rd_done);
      if_rvalid <= fe_done;
      if_err    <= oor_q & fe_done;
      if (rd_done) ls_rdata <= oor_q ? '0 : mem_dout;
      if (fe_done) if_rdata <= oor_q ? '0 : mem_fetch;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: drivers push expected responses at grant, a monitor pops and compares.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic        if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_wdone, ls_err, mem_enable;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_din;
  logic [1:0]  mem_rw;
  logic [31:0] mem_dout = '0;
  logic [31:0] mem_fetch = '0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_wdone(ls_wdone), .ls_rdata(ls_rdata),
    .ls_err(ls_err),
    .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_din(mem_din), .mem_enable(mem_enable),
    .mem_dout(mem_dout), .mem_fetch(mem_fetch)
  );

  typedef struct { int cyc; bit st; logic [31:0] data; bit err; } rsp_t;
  typedef struct { int cyc; logic [1:0] rw; logic [31:0] addr; logic [31:0] din; bit wr; } iss_t;

  rsp_t        ls_q[$], if_q[$];
  iss_t        iss_q[$];
  logic [31:0] ram [0:255];
  logic [31:0] ref_mem [0:255];
  bit          ram_loaded = 1'b0;
  int          errors = 0, checks = 0, cyc = 0;
  bit          in_reset = 1'b1;
  bit          mon_last_ls = 1'b0;
  rsp_t        mon_rsp;
  iss_t        mon_iss;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h1234_5678 : ((32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) == 0) return a | 32'h0001_0000;
    return {24'h0, a[7:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected or never seen (cycle %0d)", name, cyc);
  endtask

  // Synchronous word RAM: registered read/fetch data, write on enable.
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (mem_enable) begin
      case (mem_rw)
        2'b10:   ram[mem_addr[7:0]] <= mem_din;
        2'b01:   mem_dout <= ram[mem_addr[7:0]];
        default: mem_fetch <= ram[mem_addr[7:0]];
      endcase
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: transaction effect decided at grant time, in grant order.
  task automatic ls_push();
    rsp_t r;
    bit   oor;
    oor    = (ls_addr[31:16] != 16'h0);
    r.cyc  = cyc + (ls_we ? 2 : 3);
    r.st   = ls_we;
    r.err  = oor;
    r.data = '0;
    if (ls_we) begin
      if (!oor) ref_mem[ls_addr[7:0]] = ls_wdata;
    end else if (!oor) begin
      r.data = ref_mem[ls_addr[7:0]];
    end
    ls_q.push_back(r);
    if (!oor) iss_q.push_back('{cyc + 1, ls_we ? 2'b10 : 2'b01, ls_addr, ls_wdata, ls_we});
  endtask

  task automatic if_push();
    rsp_t r;
    bit   oor;
    oor    = (if_addr[31:16] != 16'h0);
    r.cyc  = cyc + 3;
    r.st   = 1'b0;
    r.err  = oor;
    r.data = oor ? 32'h0 : ref_mem[if_addr[7:0]];
    if_q.push_back(r);
    if (!oor) iss_q.push_back('{cyc + 1, 2'b00, if_addr, 32'h0, 1'b0});
  endtask

  task automatic ls_wait_gnt(input bit withdraw, output int gcyc);
    gcyc = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (ls_gnt) begin gcyc = cyc; ls_push(); break; end
      if (withdraw && k >= 1) break;
    end
    if (gcyc < 0 && !withdraw) note_fail("ls_gnt_timeout");
    @(posedge clk); #1;
  endtask

  task automatic if_wait_gnt(input bit withdraw, output int gcyc);
    gcyc = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (if_gnt) begin gcyc = cyc; if_push(); break; end
      if (withdraw && k >= 1) break;
    end
    if (gcyc < 0 && !withdraw) note_fail("if_gnt_timeout");
    @(posedge clk); #1;
  endtask

  task automatic ls_random(input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 6)) @(posedge clk);
      #1;
      ls_req   = 1'b1;
      ls_we    = 1'($urandom_range(0, 1));
      ls_addr  = rand_addr();
      ls_wdata = $urandom;
      ls_wait_gnt($urandom_range(0, 9) == 0, g);
      ls_req = 1'b0;
    end
  endtask

  task automatic if_random(input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      if_req  = 1'b1;
      if_addr = rand_addr();
      if_wait_gnt($urandom_range(0, 9) == 0, g);
      if_req = 1'b0;
    end
  endtask

  // Monitor: arbitration rule, RAM issue and responses against the queues.
  always @(negedge clk) begin
    if (in_reset) begin
      mon_last_ls = 1'b0;
    end else begin
      if (ls_gnt || if_gnt) begin
        chk("gnt_onehot", 64'(ls_gnt & if_gnt), 64'h0);
`ifdef MEM_ACCESS_RR_EN
        if (ls_req && if_req) chk("rr_tie_winner", 64'(ls_gnt), 64'(!mon_last_ls));
`else
        if (ls_req) chk("fixed_ls_priority", 64'(ls_gnt), 64'h1);
`endif
        mon_last_ls = ls_gnt;
      end
      if (mem_enable) begin
        if (iss_q.size() == 0) note_fail("unexpected_mem_enable");
        else begin
          mon_iss = iss_q.pop_front();
          chk("issue_cycle", 64'(cyc), 64'(mon_iss.cyc));
          chk("issue_rw", 64'(mem_rw), 64'(mon_iss.rw));
          chk("issue_addr", 64'(mem_addr), 64'(mon_iss.addr));
          if (mon_iss.wr) chk("issue_din", 64'(mem_din), 64'(mon_iss.din));
        end
      end
      if (ls_rvalid || ls_wdone) begin
        if (ls_q.size() == 0) note_fail("unexpected_ls_response");
        else begin
          mon_rsp = ls_q.pop_front();
          chk("ls_rsp_cycle", 64'(cyc), 64'(mon_rsp.cyc));
          chk("ls_rsp_kind", 64'({ls_wdone, ls_rvalid}), mon_rsp.st ? 64'h2 : 64'h1);
          chk("ls_err", 64'(ls_err), 64'(mon_rsp.err));
          if (!mon_rsp.st) chk("ls_rdata", 64'(ls_rdata), 64'(mon_rsp.data));
        end
      end
      if (if_rvalid) begin
        if (if_q.size() == 0) note_fail("unexpected_if_response");
        else begin
          mon_rsp = if_q.pop_front();
          chk("if_rsp_cycle", 64'(cyc), 64'(mon_rsp.cyc));
          chk("if_err", 64'(if_err), 64'(mon_rsp.err));
          chk("if_rdata", 64'(if_rdata), 64'(mon_rsp.data));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, prev;
    bit rv, en;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    reset_n = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    #3;
    chk("reset_outputs_zero", 64'(|{if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid,
        ls_wdone, ls_rdata, ls_err, mem_addr, mem_rw, mem_din, mem_enable}), 64'h0);
    repeat (2) @(posedge clk);
    #1; reset_n = 1'b1; in_reset = 1'b0;
    @(posedge clk); #1;

    // Reset in the ISSUE cycle of a load drops it.
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
    ls_wait_gnt(1'b0, g);
    ls_req = 1'b0;
    in_reset = 1'b1; reset_n = 1'b0;
    #1;
    chk("reset_mid_issue_zero", 64'(|{if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid,
        ls_wdone, ls_rdata, ls_err, mem_addr, mem_rw, mem_din, mem_enable}), 64'h0);
    ls_q.delete(); if_q.delete(); iss_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1; in_reset = 1'b0;
    rv = 1'b0; en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rv |= ls_rvalid;
      en |= mem_enable;
    end
    chk("no_rvalid_after_reset", 64'(rv), 64'h0);
    chk("idle_enable_low", 64'(en), 64'h0);
    @(posedge clk); #1;

    // Store then load at 0x10, fetch 0x4, out-of-range load.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h10; ls_wdata = 32'hDEAD_BEEF;
    ls_wait_gnt(1'b0, g); ls_req = 1'b0;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h10;
    ls_wait_gnt(1'b0, g); ls_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h4;
    if_wait_gnt(1'b0, g); if_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0001_0000;
    ls_wait_gnt(1'b0, g); ls_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Back-to-back loads with ls_req held.
    ls_req = 1'b1; ls_we = 1'b0; prev = 0;
    for (int i = 0; i < 4; i++) begin
      ls_addr = 32'h10 + 32'(i);
      ls_wait_gnt(1'b0, g);
      if (i > 0) chk("b2b_grant_spacing", 64'(g - prev), 64'd3);
      prev = g;
    end
    ls_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Both requesters held with reads.
    fork
      begin : held_ls
        int gl;
        ls_req = 1'b1; ls_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
          ls_addr = 32'h20 + 32'(i);
          ls_wait_gnt(1'b0, gl);
        end
        ls_req = 1'b0;
      end
      begin : held_if
        int gi;
        if_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
          if_addr = 32'h30 + 32'(i);
          if_wait_gnt(1'b0, gi);
        end
        if_req = 1'b0;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    fork
      ls_random(60);
      if_random(60);
    join

    for (int k = 0; k < 50; k++) begin
      if (ls_q.size() == 0 && if_q.size() == 0 && iss_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_ls_queue", 64'(ls_q.size()), 64'h0);
    chk("drain_if_queue", 64'(if_q.size()), 64'h0);
    chk("drain_issue_queue", 64'(iss_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
